// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared sequencer state, config select codes and channel-width helper for the TDM NCO
package nco_pkg;

   typedef enum logic {
      SEQ_IDLE  = 1'b0,
      SEQ_SWEEP = 1'b1
   } seq_state_t;

   localparam logic CFG_SEL_INC = 1'b0;
   localparam logic CFG_SEL_OFF = 1'b1;

   function automatic int ch_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/nco_qlut.sv
// rtl/nco_qlut.sv - quarter-wave sine table, half-LSB offset so every entry is strictly positive
module nco_qlut #(
   parameter int DATA_WIDTH = 12,
   parameter int QLUT_DEPTH = 8
) (
   input  logic [QLUT_DEPTH-3:0] address,
   output logic [DATA_WIDTH-2:0] value
);

   localparam int ENTRIES = 2 ** (QLUT_DEPTH - 2);

   function automatic int entry_value(input int i);
      real amp;
      real ang;
      amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
      ang = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(ENTRIES);
      return $rtoi(amp * $sin(ang) + 0.5);
   endfunction

   logic [DATA_WIDTH-2:0] rom [ENTRIES];

   for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
      localparam int ENTRY = entry_value(i);
      assign rom[i] = (DATA_WIDTH-1)'(ENTRY);
   end

   assign value = rom[address];

endmodule

// File: rtl/tdm_quadrature_nco.sv
// rtl/tdm_quadrature_nco.sv - time-multiplexed multi-channel quadrature NCO
// One channel per clk during a sweep; 3-stage phase -> quadrant -> table pipeline.
module tdm_quadrature_nco
   import nco_pkg::*;
#(
   parameter int  DATA_WIDTH  = 12,
   parameter int  QLUT_DEPTH  = 8,
   parameter int  PHASE_WIDTH = 32,
   parameter int  NUM_CH      = 4,
   localparam int CH_W        = ch_width(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         sample_clk_ce,
   input  logic                         sync_clr,
   input  logic                         cfg_we,
   input  logic [CH_W-1:0]              cfg_ch,
   input  logic                         cfg_sel,
   input  logic [PHASE_WIDTH-1:0]       cfg_data,
   output logic                         out_valid,
   output logic [CH_W-1:0]              out_ch,
   output logic signed [DATA_WIDTH-1:0] sinewave,
   output logic signed [DATA_WIDTH-1:0] cosinewave,
   output logic                         overrun
);

   localparam int              AW        = QLUT_DEPTH - 2;
   localparam logic [CH_W-1:0] LAST_STEP = CH_W'(NUM_CH - 1);

   seq_state_t       state, state_nxt;
   logic [CH_W-1:0]  step, step_nxt;
   logic             start;
   logic             proc;

   logic [PHASE_WIDTH-1:0] shadow_inc [NUM_CH];
   logic [PHASE_WIDTH-1:0] shadow_off [NUM_CH];
   logic [PHASE_WIDTH-1:0] active_inc [NUM_CH];
   logic [PHASE_WIDTH-1:0] active_off [NUM_CH];
   logic [PHASE_WIDTH-1:0] acc        [NUM_CH];

   logic [PHASE_WIDTH-1:0] sel_acc, sel_inc, sel_off;
   logic [QLUT_DEPTH-1:0]  phase_top;

   logic                  s1_valid;
   logic [CH_W-1:0]       s1_ch;
   logic [QLUT_DEPTH-1:0] s1_phase;
   logic                  s2_valid;
   logic [CH_W-1:0]       s2_ch;
   logic [AW-1:0]         s2_sin_idx, s2_cos_idx;
   logic                  s2_sin_neg, s2_cos_neg;
   logic [DATA_WIDTH-2:0] sin_val, cos_val;
   logic signed [DATA_WIDTH-1:0] sin_mag, cos_mag;

   // Step 0 is processed in the very cycle sample_clk_ce is accepted.
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      start     = 1'b0;
      if (sync_clr) begin
         state_nxt = SEQ_IDLE;
         step_nxt  = '0;
      end else if (state == SEQ_IDLE) begin
         if (sample_clk_ce) begin
            start = 1'b1;
            if (NUM_CH > 1) begin
               state_nxt = SEQ_SWEEP;
               step_nxt  = CH_W'(1);
            end
         end
      end else if (step == LAST_STEP) begin
         state_nxt = SEQ_IDLE;
         step_nxt  = '0;
      end else begin
         step_nxt = step + CH_W'(1);
      end
   end

   assign proc = start | ((state == SEQ_SWEEP) & ~sync_clr);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= SEQ_IDLE;
         step    <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         if (sample_clk_ce && state == SEQ_SWEEP)
            overrun <= 1'b1;
      end
   end

   // The starting step sees the shadow values the active set is loading this cycle.
   always_comb begin
      sel_acc = '0;
      sel_inc = '0;
      sel_off = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (step == CH_W'(k)) begin
            sel_acc = acc[k];
            sel_inc = start ? shadow_inc[k] : active_inc[k];
            sel_off = start ? shadow_off[k] : active_off[k];
         end
      end
   end

   assign phase_top = QLUT_DEPTH'((sel_acc + sel_off) >> (PHASE_WIDTH - QLUT_DEPTH));

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_inc[k] <= '0;
            shadow_off[k] <= '0;
            active_inc[k] <= '0;
            active_off[k] <= '0;
            acc[k]        <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_we && cfg_ch == CH_W'(k)) begin
               if (cfg_sel == CFG_SEL_INC)
                  shadow_inc[k] <= cfg_data;
               else
                  shadow_off[k] <= cfg_data;
            end
            if (start) begin
               active_inc[k] <= shadow_inc[k];
               active_off[k] <= shadow_off[k];
            end
            if (sync_clr)
               acc[k] <= '0;
            else if (proc && step == CH_W'(k))
               acc[k] <= acc[k] + sel_inc;
         end
      end
   end

   nco_qlut #(.DATA_WIDTH(DATA_WIDTH), .QLUT_DEPTH(QLUT_DEPTH)) u_sin_lut (
      .address (s2_sin_idx),
      .value   (sin_val)
   );

   nco_qlut #(.DATA_WIDTH(DATA_WIDTH), .QLUT_DEPTH(QLUT_DEPTH)) u_cos_lut (
      .address (s2_cos_idx),
      .value   (cos_val)
   );

   assign sin_mag = {1'b0, sin_val};
   assign cos_mag = {1'b0, cos_val};

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s1_valid   <= 1'b0;
         s1_ch      <= '0;
         s1_phase   <= '0;
         s2_valid   <= 1'b0;
         s2_ch      <= '0;
         s2_sin_idx <= '0;
         s2_cos_idx <= '0;
         s2_sin_neg <= 1'b0;
         s2_cos_neg <= 1'b0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         sinewave   <= '0;
         cosinewave <= '0;
      end else begin
         s1_valid <= proc;
         if (proc) begin
            s1_ch    <= step;
            s1_phase <= phase_top;
         end

         // Quadrant fold: p1 = half-wave, p0 = mirrored quarter.
         s2_valid   <= s1_valid & ~sync_clr;
         s2_ch      <= s1_ch;
         s2_sin_idx <= s1_phase[QLUT_DEPTH-2] ? ~s1_phase[AW-1:0] : s1_phase[AW-1:0];
         s2_cos_idx <= s1_phase[QLUT_DEPTH-2] ? s1_phase[AW-1:0] : ~s1_phase[AW-1:0];
         s2_sin_neg <= s1_phase[QLUT_DEPTH-1];
         s2_cos_neg <= s1_phase[QLUT_DEPTH-1] ^ s1_phase[QLUT_DEPTH-2];

         out_valid <= s2_valid & ~sync_clr;
         if (s2_valid && !sync_clr) begin
            out_ch     <= s2_ch;
            sinewave   <= s2_sin_neg ? -sin_mag : sin_mag;
            cosinewave <= s2_cos_neg ? -cos_mag : cos_mag;
         end
      end
   end

endmodule

// File: tb/tb_tdm_quadrature_nco.sv
// tb/tb_tdm_quadrature_nco.sv - directed self-checking bench for tdm_quadrature_nco
module tb_tdm_quadrature_nco;

   logic               clk = 1'b0;
   logic               arst_n = 1'b0;
   logic               sample_clk_ce = 1'b0;
   logic               sync_clr = 1'b0;
   logic               cfg_we = 1'b0;
   logic [1:0]         cfg_ch = '0;
   logic               cfg_sel = 1'b0;
   logic [31:0]        cfg_data = '0;
   logic               out_valid;
   logic [1:0]         out_ch;
   logic signed [11:0] sinewave;
   logic signed [11:0] cosinewave;
   logic               overrun;

   int tests_run = 0;
   int tests_failed = 0;
   int q_ch[$];
   int q_sin[$];
   int q_cos[$];
   int inc_sin[3] = '{25, 2047, -25};
   int inc_cos[3] = '{2047, -25, -2047};

   always #5 clk = ~clk;

   tdm_quadrature_nco dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .sample_clk_ce (sample_clk_ce),
      .sync_clr      (sync_clr),
      .cfg_we        (cfg_we),
      .cfg_ch        (cfg_ch),
      .cfg_sel       (cfg_sel),
      .cfg_data      (cfg_data),
      .out_valid     (out_valid),
      .out_ch        (out_ch),
      .sinewave      (sinewave),
      .cosinewave    (cosinewave),
      .overrun       (overrun)
   );

   always @(negedge clk) begin
      if (arst_n && out_valid) begin
         q_ch.push_back(int'(out_ch));
         q_sin.push_back(int'(sinewave));
         q_cos.push_back(int'(cosinewave));
      end
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] expected);
      tests_run++;
      if (got !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_ch.delete();
      q_sin.delete();
      q_cos.delete();
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [31:0] data);
      cfg_we   = 1'b1;
      cfg_ch   = ch;
      cfg_sel  = sel;
      cfg_data = data;
      tick(1);
      cfg_we   = 1'b0;
   endtask

   task automatic run_sweep();
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(8);
   endtask

   task automatic check_sample(input string tag, input int ch, input int es, input int ec);
      int idx = -1;
      foreach (q_ch[i]) if (q_ch[i] == ch) idx = i;
      check({tag, "_present"}, idx >= 0, 1);
      if (idx >= 0) begin
         check({tag, "_sin"}, q_sin[idx], es);
         check({tag, "_cos"}, q_cos[idx], ec);
      end
   endtask

   initial begin
      // reset state
      tick(3);
      check("rst_valid", out_valid, 0);
      check("rst_ch", out_ch, 0);
      check("rst_sin", sinewave, 0);
      check("rst_cos", cosinewave, 0);
      check("rst_overrun", overrun, 0);
      arst_n = 1'b1;
      tick(2);

      // first sample latency and value, all defaults
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(1);
      check("lat_early_valid", out_valid, 0);
      tick(1);
      check("lat_valid", out_valid, 1);
      check("lat_ch", out_ch, 0);
      check("lat_sin", sinewave, 25);
      check("lat_cos", cosinewave, 2047);
      tick(6);
      check("sweep0_count", q_ch.size(), 4);
      check("hold_valid", out_valid, 0);
      check("hold_ch", out_ch, 3);
      check("hold_sin", sinewave, 25);
      check("hold_cos", cosinewave, 2047);

      // quarter-turn increment on channel 1
      cfg_write(2'd1, 1'b0, 32'h4000_0000);
      for (int s = 0; s < 3; s++) begin
         run_sweep();
         check_sample($sformatf("inc_sweep%0d", s), 1, inc_sin[s], inc_cos[s]);
      end
      check_sample("inc_ch0", 0, 25, 2047);

      // offset written mid-sweep applies only from the next sweep
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      cfg_write(2'd2, 1'b1, 32'h4000_0000);
      tick(7);
      check_sample("off_cur", 2, 25, 2047);
      run_sweep();
      check_sample("off_next", 2, 2047, -25);

      // repeated start while busy
      check("ovr_before", overrun, 0);
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(1);
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(8);
      check("ovr_flag", overrun, 1);
      check("ovr_count", q_ch.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("ovr_ch%0d", i), (i < q_ch.size()) ? q_ch[i] : -1, i);

      // sync_clr at step 2
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(1);
      sync_clr = 1'b1;
      tick(1);
      sync_clr = 1'b0;
      check("clr_v0", out_valid, 0);
      tick(1);
      check("clr_v1", out_valid, 0);
      tick(1);
      check("clr_v2", out_valid, 0);
      tick(4);
      check("clr_count", q_ch.size(), 0);
      run_sweep();
      check_sample("clr_ch0", 0, 25, 2047);
      check_sample("clr_ch1", 1, 25, 2047);
      check_sample("clr_ch2", 2, 2047, -25);
      check("clr_overrun_sticky", overrun, 1);

      // clear and start together: clear wins
      clear_q();
      sync_clr = 1'b1;
      sample_clk_ce = 1'b1;
      tick(1);
      sync_clr = 1'b0;
      sample_clk_ce = 1'b0;
      tick(6);
      check("clrce_count", q_ch.size(), 0);
      run_sweep();
      check_sample("clrce_ch1", 1, 25, 2047);

      // asynchronous reset mid-sweep
      clear_q();
      sample_clk_ce = 1'b1;
      tick(1);
      sample_clk_ce = 1'b0;
      tick(2);
      check("pre_rst_valid", out_valid, 1);
      arst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_ch", out_ch, 0);
      check("arst_sin", sinewave, 0);
      check("arst_cos", cosinewave, 0);
      check("arst_overrun", overrun, 0);
      tick(2);
      arst_n = 1'b1;
      clear_q();
      tick(8);
      check("arst_no_partial", q_ch.size(), 0);
      run_sweep();
      check("arst_count", q_ch.size(), 4);
      check_sample("arst_ch1", 1, 25, 2047);
      check_sample("arst_ch2", 2, 25, 2047);
      run_sweep();
      check_sample("arst_ch1_next", 1, 25, 2047);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tdm_quadrature_nco.md
TDM_QUADRATURE_NCO -- requirements
Module: tdm_quadrature_nco

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, signed output sample width.
REQ-002 SHALL have parameter QLUT_DEPTH, default 8, full-wave phase resolution in bits; the quarter table holds 2^(QLUT_DEPTH-2) entries.
REQ-003 SHALL have parameter PHASE_WIDTH, default 32, phase accumulator width.
REQ-004 SHALL have parameter NUM_CH, default 4 (range 1..16), number of time-multiplexed channels; CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port sample_clk_ce, input, 1, starts one sweep over all channels.
REQ-008 SHALL have port sync_clr, input, 1, synchronous clear of all accumulators.
REQ-009 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-010 SHALL have port cfg_ch, input, CH_W, target channel of the write.
REQ-011 SHALL have port cfg_sel, input, 1, 0 = phase increment, 1 = phase offset.
REQ-012 SHALL have port cfg_data, input, PHASE_WIDTH, write data.
REQ-013 SHALL have port out_valid, output, 1, marks one channel sample.
REQ-014 SHALL have port out_ch, output, CH_W, channel of the current sample.
REQ-015 SHALL have ports sinewave and cosinewave, output, DATA_WIDTH signed, quadrature samples.
REQ-016 SHALL have port overrun, output, 1, sticky flag for a sample_clk_ce received while busy.

Function
REQ-017 SHALL hold per channel: shadow and active increment, shadow and active offset, and the accumulator acc[k].
REQ-018 cfg_we SHALL write the shadow register in the cycle it is high; a cfg_ch value of NUM_CH or more SHALL be ignored.
REQ-019 Active registers SHALL load from shadow only in the sample_clk_ce cycle that starts a sweep, so that a sweep never mixes settings.
REQ-020 Sequencer states: IDLE and SWEEP. In IDLE, sample_clk_ce moves to SWEEP with step 0 in the same cycle; the step advances 0..NUM_CH-1 one per clk, then returns to IDLE.
REQ-021 At step k: phase = acc[k] + offset[k] mod 2^PHASE_WIDTH, and acc[k] <= acc[k] + inc[k], wrapping.
REQ-022 Quadrant mapping from the phase top bits p1:p0 and idx = phase[PW-3 : PW-QLUT_DEPTH]:
- sine index = p0 ? ~idx : idx, negate = p1.
- cosine index = p0 ? idx : ~idx, negate = p1 ^ p0.
REQ-023 Table entry i SHALL equal round((2^(DATA_WIDTH-1)-1) * sin(pi/2 * (i+0.5) / 2^(QLUT_DEPTH-2))); all entries are positive, so negation never overflows.
REQ-024 Pipeline: stage 1 registers the phase; stage 2 registers index and negate; stage 3 registers the signed table output. The sample for step k appears with out_valid=1 and out_ch=k exactly 3 clk after step k.
REQ-025 sample_clk_ce in SWEEP SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-026 sync_clr SHALL zero every acc, abort any sweep, return to IDLE and flush valid in flight, so out_valid is 0 for the next 3 cycles. If sync_clr and sample_clk_ce are high together, clear wins and no sweep starts.
REQ-027 sinewave, cosinewave and out_ch SHALL hold their last values while out_valid=0.

Reset
REQ-028 While arst_n=0, all state SHALL be zero: accumulators, shadow and active registers, sequencer (IDLE), pipeline, sinewave, cosinewave, out_ch, out_valid and overrun.
REQ-029 Reset mid-sweep SHALL take effect immediately; no partial samples are emitted after release.

Structure
REQ-030 Package nco_pkg SHALL hold the sequencer state enum, the cfg_sel encodings and the CH_W helper function.
REQ-031 One combinational sub-module nco_qlut(address, value) SHALL be instantiated twice, once for sine and once for cosine.

Verification
REQ-032 Defaults, inc[0]=0, offset 0, one sample_clk_ce -> ch0 sample at +3 cycles: sin=25, cos=2047.
REQ-033 inc[1]=2^30, three sweeps -> ch1 outputs (sin, cos) = (25, 2047), (2047, -25), (-25, -2047).
REQ-034 offset[2] written during an active sweep -> current sweep unchanged; the next sweep reflects the new offset.
REQ-035 sample_clk_ce repeated 2 cycles after a sweep start -> it is ignored, overrun=1, and exactly NUM_CH valid samples are emitted, out_ch 0..3.
REQ-036 sync_clr at step 2 -> no further out_valid pulses from that sweep after 3 cycles, and the next sweep gives ch0 sin=25, cos=2047.
REQ-037 arst_n low mid-sweep -> all outputs 0 at once; after release, the first sweep restarts from phase 0.
